// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and tick derivation for the PWM capture block.
package pwm_pkg;

  localparam int DUTY_W           = 10;
  localparam int DUTY_FULL        = 1024;
  localparam int PERIOD_W         = 12;
  localparam int DEF_CLK_FREQ_MHZ = 50;
  localparam int DEF_PERIOD_NS    = 20000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Clock cycles per duty LSB (floor); 64-bit product avoids overflow for fast clocks.
  function automatic int tick_cycles(input int clk_mhz, input int period_ns);
    return int'((longint'(clk_mhz) * longint'(period_ns) / 64'sd1000) / longint'(DUTY_FULL));
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the raw PWM input and emits registered rise/fall pulses.
// Optional PWM_GLITCH_FILTER_EN inserts a stability filter (7 clk added latency).
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [2:0] run_q, run_d;

  // A new level is adopted once the synchronized input has disagreed with the
  // filtered level for a full run; any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == 3'd6) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      rise_q <= lvl & ~lvl_q;
      fall_q <= ~lvl & lvl_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Servo PWM decoder: measures high time and period in 1/1024-period ticks,
// flags out-of-tolerance periods and loss of signal. Option: PWM_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ_MHZ  = DEF_CLK_FREQ_MHZ,
  parameter int PERIOD_NS     = DEF_PERIOD_NS,
  parameter int TICK_CYCLES   = tick_cycles(CLK_FREQ_MHZ, PERIOD_NS),
  parameter int PERIOD_TOL    = 64,
  parameter int TIMEOUT_TICKS = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [DUTY_W-1:0]   duty_out,
  output logic [PERIOD_W-1:0] period_ticks,
  output logic                sample_valid,
  output logic                period_err,
  output logic                signal_lost
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_TICKS);
  localparam logic [PERIOD_W-1:0] PER_MIN    = PERIOD_W'(DUTY_FULL - PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] PER_MAX    = PERIOD_W'(DUTY_FULL + PERIOD_TOL);

  function automatic logic [DUTY_W-1:0] sat_inc_duty(input logic [DUTY_W-1:0] v);
    return (&v) ? v : v + DUTY_W'(1);
  endfunction

  function automatic logic [PERIOD_W-1:0] sat_inc_per(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  logic rise, fall, any_edge;
  logic presc_wrap, tick, timeout;
  logic emit;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [DUTY_W-1:0]   high_cnt_q;
  logic [PERIOD_W-1:0] per_cnt_q;

  logic [DUTY_W-1:0]   duty_q;
  logic [PERIOD_W-1:0] period_q;
  logic                valid_q, err_q, lost_q;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // A rising edge restarts the prescaler, so a tick coinciding with it is dropped.
  assign any_edge   = rise | fall;
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign tick       = presc_wrap & ~rise;
  assign timeout    = tick & ~fall & (idle_q == IDLE_LAST);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (timeout)   state_d = ST_IDLE;
        else if (fall) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_HIGH;
          emit    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      idle_q     <= '0;
      high_cnt_q <= '0;
      per_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= (rise || presc_wrap) ? '0 : presc_q + PRESC_W'(1);

      if (any_edge)                          idle_q <= '0;
      else if (tick && (idle_q != IDLE_MAX)) idle_q <= idle_q + IDLE_W'(1);

      // The high count stops at the falling edge; the period keeps running until the next rise.
      if (rise || (state_q == ST_IDLE)) begin
        high_cnt_q <= '0;
        per_cnt_q  <= '0;
      end else if (tick) begin
        per_cnt_q <= sat_inc_per(per_cnt_q);
        if ((state_q == ST_HIGH) && !fall) high_cnt_q <= sat_inc_duty(high_cnt_q);
      end
    end
  end

  // Output stage: captured values hold across signal loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      valid_q <= emit;
      if (emit) begin
        duty_q   <= high_cnt_q;
        period_q <= per_cnt_q;
        err_q    <= (per_cnt_q < PER_MIN) || (per_cnt_q > PER_MAX);
        lost_q   <= 1'b0;
      end else if (timeout) begin
        lost_q   <= 1'b1;
      end
    end
  end

  assign duty_out     = duty_q;
  assign period_ticks = period_q;
  assign sample_valid = valid_q;
  assign period_err   = err_q;
  assign signal_lost  = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with a shortened tick (3 clk per duty LSB).
module tb_pwm_capture;

  localparam int TICK = 3;
  localparam int TOL  = 64;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT  = 11;
`else
  localparam int LAT  = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [9:0]  duty_out;
  logic [11:0] period_ticks;
  logic        sample_valid, period_err, signal_lost;

  pwm_capture #(
    .TICK_CYCLES   (TICK),
    .PERIOD_TOL    (TOL),
    .TIMEOUT_TICKS (2048)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .duty_out     (duty_out),
    .period_ticks (period_ticks),
    .sample_valid (sample_valid),
    .period_err   (period_err),
    .signal_lost  (signal_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int per;
    int err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;
  int   since = 0;
  int   high_len = 0;
  bit   armed = 1'b0;
  bit   cur = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_duty",   32'(duty_out), 0);
    check("rst_period", 32'(period_ticks), 0);
    check("rst_valid",  32'(sample_valid), 0);
    check("rst_err",    32'(period_err), 0);
    check("rst_lost",   32'(signal_lost), 1);
  endtask

  // Expected sample for a completed rise-to-rise cycle of h high clk and p total clk.
  function automatic void model_push(int h, int p);
    exp_t e;
    e.duty = (h / TICK > 1023) ? 1023 : h / TICK;
    e.per  = (p / TICK > 4095) ? 4095 : p / TICK;
    e.err  = ((e.per < 1024 - TOL) || (e.per > 1024 + TOL)) ? 1 : 0;
    q.push_back(e);
  endfunction

  task automatic drive(input bit lvl, input int n);
    if (lvl && !cur) begin
      if (armed) model_push(high_len, since);
      armed = 1'b1;
      since = 0;
      last_rise_cyc = cyc;
    end else if (!lvl && cur) begin
      high_len = since;
    end
    cur = lvl;
    pwm_in = lvl;
    repeat (n) @(negedge clk);
    since += n;
  endtask

  task automatic pwm_cycle(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic glitch_cycle(input int h, input int at, input int g, input int p);
    drive(1'b1, at);
`ifdef PWM_GLITCH_FILTER_EN
    pwm_in = 1'b0;
    repeat (g) @(negedge clk);
    since += g;
    pwm_in = 1'b1;
    drive(1'b1, h - at - g);
`else
    drive(1'b0, g);
    drive(1'b1, h - at - g);
`endif
    drive(1'b0, p - h);
  endtask

  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      check("valid_one_cycle", 32'(prev_valid), 0);
      if (q.size() == 0) begin
        check("sample_unexpected", 32'(sample_valid), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", 32'(cyc - last_rise_cyc), LAT);
        check("duty",    32'(duty_out), 32'(e.duty));
        check("period",  32'(period_ticks), 32'(e.per));
        check("per_err", 32'(period_err), 32'(e.err));
        check("lost_clr", 32'(signal_lost), 0);
      end
    end
    prev_valid <= sample_valid;
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Nominal train, then several duties and a short period.
    repeat (3) pwm_cycle(229, 3074);
    pwm_cycle(244, 3074);
    pwm_cycle(61, 3074);
    pwm_cycle(229, 2458);
    pwm_cycle(229, 3074);
    glitch_cycle(230, 62, 5, 3074);
    pwm_cycle(229, 3074);

    // Hold high until signal loss; outputs must hold the last sample.
    drive(1'b1, 5000);
    check("lost_early", 32'(signal_lost), 0);
    n = 0;
    while (!signal_lost && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("lost_timeout", 32'(signal_lost), 1);
    check("hold_duty",    32'(duty_out), 76);
    check("hold_period",  32'(period_ticks), 1024);
    armed = 1'b0;

    // Recovery: first rise only arms, the second rise produces a sample.
    drive(1'b0, 100);
    drive(1'b1, 229);
    check("lost_first_cycle", 32'(signal_lost), 1);
    drive(1'b0, 3074 - 229);
    pwm_cycle(244, 3074);
    drive(1'b1, 50);
    check("lost_recovered", 32'(signal_lost), 0);

    // Asynchronous reset in the middle of a high phase.
    drive(1'b1, 60);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    check("queue_at_reset", 32'(q.size()), 0);
    armed = 1'b0;
    cur = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pwm_cycle(229, 3074);
    check("no_sample_after_reset", 32'(duty_out), 0);
    pwm_cycle(61, 3074);
    drive(1'b1, 40);
    drive(1'b0, 20);
    check("queue_drained", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
